// File: rtl/mic_capture_ctrl.sv
// ============================================================================
// mic_capture_ctrl : one mic recording session (warm-up discard, store to RAM)
//                    plus write-priority arbitration of the single RAM port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mic_capture_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18,
  parameter int WARMUP = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] len,
  output logic              mic_en,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RECORD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int             WW        = $clog2(WARMUP + 1) + 1;
  localparam logic [WW-1:0]  WARM_LAST = WW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic [ADDR_W:0]   target;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] last_addr;
  logic [WW-1:0]     warm_cnt;
  logic              pend_valid;
  logic [DATA_W-1:0] pend_data;
  logic              stop_flag;
  logic              alive;
  logic [ADDR_W:0]   cnt_nxt;

  assign cnt_nxt   = sample_count + (ADDR_W + 1)'(1);
  assign mem_we    = pend_valid;
  assign mem_wdata = pend_data;
  assign busy      = (state == S_WARMUP) || (state == S_RECORD);
  assign mic_en    = busy;
  assign done      = (state == S_DONE);

  // alive keeps the reader from being granted while reset is held
  always_comb begin
    mem_addr = last_addr;
    rd_gnt   = 1'b0;
    if (pend_valid) begin
      mem_addr = wptr;
    end else if (rd_req && alive) begin
      rd_gnt   = 1'b1;
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      target       <= '0;
      wptr         <= '0;
      last_addr    <= '0;
      warm_cnt     <= '0;
      pend_valid   <= 1'b0;
      pend_data    <= '0;
      stop_flag    <= 1'b0;
      alive        <= 1'b0;
      sample_count <= '0;
    end else begin
      alive     <= 1'b1;
      last_addr <= mem_addr;
      if (pend_valid) begin
        pend_valid   <= 1'b0;
        wptr         <= wptr + ADDR_W'(1);
        sample_count <= cnt_nxt;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            target       <= (len == '0) ? FULL_LEN : {1'b0, len};
            sample_count <= '0;
            wptr         <= '0;
            warm_cnt     <= '0;
            stop_flag    <= 1'b0;
            state        <= (WARMUP == 0) ? S_RECORD : S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (stop) begin
            state <= S_DONE;
          end else if (smp_valid) begin
            if (warm_cnt == WARM_LAST) state <= S_RECORD;
            else                       warm_cnt <= warm_cnt + WW'(1);
          end
        end
        S_RECORD: begin
          if (smp_valid) begin
            pend_valid <= 1'b1;
            pend_data  <= smp_data;
          end
          // a stop coinciding with a strobe defers DONE until that sample lands
          if (pend_valid && ((cnt_nxt == target) || stop_flag)) begin
            state <= S_DONE;
          end else if (stop) begin
            if (smp_valid) stop_flag <= 1'b1;
            else           state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mic_capture_ctrl.sv
// Self-checking bench for mic_capture_ctrl: scoreboard of expected RAM writes
// (address, data, cycle) plus per-scenario inline checks.
`default_nettype none

module tb_mic_capture_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 18;
  localparam int WARMUP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic              mic_en;
  logic              smp_valid = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_gnt;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  mic_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .len(len),
    .mic_en(mic_en), .smp_valid(smp_valid), .smp_data(smp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .busy(busy), .done(done), .sample_count(sample_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (reset && mem_we) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: addr=%0d data=%0h cyc=%0d, required no write",
                 mem_addr, mem_wdata, cyc);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL write_sb: addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit store,
                      input logic [ADDR_W-1:0] a, input bit with_stop);
    wr_t w;
    smp_valid = 1'b1;
    smp_data  = d;
    stop      = with_stop;
    if (store) begin
      w.addr = a;
      w.data = d;
      w.cyc  = cyc + 1;
      sb.push_back(w);
    end
    tick();
    smp_valid = 1'b0;
    stop      = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({mic_en, mem_we, mem_addr, mem_wdata, rd_gnt, busy, done, sample_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: mic_en=%b we=%b addr=%0d wdata=%0h gnt=%b busy=%b done=%b cnt=%0d, required all 0",
               mic_en, mem_we, mem_addr, mem_wdata, rd_gnt, busy, done, sample_count);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pulse_start(ADDR_W'(8));
    n_checks++;
    if (mic_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_mic_en: mic_en=%b busy=%b, required 1 1", mic_en, busy);
    end
    for (int i = 1; i <= 12; i++)
      send(DATA_W'(i), i > 4, ADDR_W'(i - 5), 1'b0);
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd8 || mic_en !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b cnt=%0d mic_en=%b pending=%0d, required 1 8 0 0",
               done, sample_count, mic_en, sb.size());
    end
  endtask

  task automatic test_len_zero();
    pulse_start('0);
    for (int i = 0; i < 20; i++)
      send(DATA_W'(18'h2A000 + i), i >= 4, ADDR_W'(i - 4), 1'b0);
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd16 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL len_zero: done=%b cnt=%0d pending=%0d, required 1 16 0",
               done, sample_count, sb.size());
    end
  endtask

  task automatic test_stop();
    pulse_start(ADDR_W'(10));
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h100 + i), 1'b0, '0, 1'b0);
    send(18'h3C001, 1'b1, ADDR_W'(0), 1'b0);
    send(18'h3C002, 1'b1, ADDR_W'(1), 1'b0);
    send(18'h3C003, 1'b1, ADDR_W'(2), 1'b1);
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd3 || mic_en !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stop_record: done=%b cnt=%0d mic_en=%b pending=%0d, required 1 3 0 0",
               done, sample_count, mic_en, sb.size());
    end
    pulse_start(ADDR_W'(10));
    send(18'h00011, 1'b0, '0, 1'b0);
    send(18'h00022, 1'b0, '0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_warmup: done=%b cnt=%0d busy=%b, required 1 0 0",
               done, sample_count, busy);
    end
    tick(); tick();
  endtask

  task automatic test_read_arb();
    wr_t w;
    pulse_start(ADDR_W'(8));
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h200 + i), 1'b0, '0, 1'b0);
    rd_req    = 1'b1;
    rd_addr   = ADDR_W'(5);
    smp_valid = 1'b1;
    smp_data  = 18'h15A5A;
    w.addr = '0; w.data = 18'h15A5A; w.cyc = cyc + 1;
    sb.push_back(w);
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b1 || mem_addr !== ADDR_W'(5) || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_idle_grant: gnt=%b addr=%0d we=%b, required 1 5 0", rd_gnt, mem_addr, mem_we);
    end
    tick();
    smp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(0)) begin
      n_fail++;
      $display("FAIL rd_blocked: gnt=%b we=%b addr=%0d, required 0 1 0", rd_gnt, mem_we, mem_addr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b1 || mem_addr !== ADDR_W'(5) || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_write: gnt=%b addr=%0d we=%b, required 1 5 0", rd_gnt, mem_addr, mem_we);
    end
    tick();
    rd_req  = 1'b0;
    rd_addr = ADDR_W'(9);
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b0 || mem_addr !== ADDR_W'(5) || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL port_idle_hold: gnt=%b addr=%0d we=%b, required 0 5 0", rd_gnt, mem_addr, mem_we);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rd_session_end: done=%b cnt=%0d pending=%0d, required 1 1 0",
               done, sample_count, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(ADDR_W'(10));
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h300 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h3F0F0 + i), 1'b1, ADDR_W'(i), 1'b0);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({mic_en, mem_we, mem_addr, mem_wdata, rd_gnt, busy, done, sample_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: mic_en=%b we=%b addr=%0d wdata=%0h gnt=%b busy=%b done=%b cnt=%0d, required all 0",
               mic_en, mem_we, mem_addr, mem_wdata, rd_gnt, busy, done, sample_count);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    pulse_start(ADDR_W'(2));
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h400 + i), 1'b0, '0, 1'b0);
    send(18'h0ABCD, 1'b1, ADDR_W'(0), 1'b0);
    send(18'h0BCDE, 1'b1, ADDR_W'(1), 1'b0);
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rerecord: done=%b cnt=%0d pending=%0d, required 1 2 0",
               done, sample_count, sb.size());
    end
  endtask

  task automatic test_start_ignored();
    pulse_start(ADDR_W'(3));
    for (int i = 0; i < 4; i++) send(DATA_W'(18'h500 + i), 1'b0, '0, 1'b0);
    send(18'h11111, 1'b1, ADDR_W'(0), 1'b0);
    start = 1'b1;
    len   = ADDR_W'(1);
    tick();
    start = 1'b0;
    tick();
    send(18'h22222, 1'b1, ADDR_W'(1), 1'b0);
    send(18'h33333, 1'b1, ADDR_W'(2), 1'b0);
    n_checks++;
    if (done !== 1'b1 || sample_count !== 5'd3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL start_in_record: done=%b cnt=%0d pending=%0d, required 1 3 0",
               done, sample_count, sb.size());
    end
    pulse_start(ADDR_W'(5));
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sample_count !== 5'd0) begin
      n_fail++;
      $display("FAIL start_in_done: done=%b busy=%b cnt=%0d, required 0 1 0",
               done, busy, sample_count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_stop();
    test_read_arb();
    test_reset_mid();
    test_start_ignored();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
- Sequences one microphone recording session around the I2S mic capture datapath:
  - enables the capture path;
  - discards the start-up (warm-up) samples;
  - stores a programmed number of 18-bit samples into a single-port sample RAM.
- Shares that one RAM port between the capture writer and a playback/readout requester. The writer has fixed priority.
- Sits between the mic capture block (supplies smp_valid/smp_data) and the sample RAM / audio playback logic.

Parameters:
ADDR_W, 12, sample RAM address width; capacity 2^ADDR_W samples
DATA_W, 18, sample width, matches mic capture output
WARMUP, 64, number of valid samples discarded after mic enable (0 = none)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle request to begin a session; honoured only in IDLE or DONE
stop  in  1  1-cycle request to end recording early
len  in  ADDR_W  samples to record, sampled on accepted start; 0 means 2^ADDR_W
mic_en  out  1  enable to mic capture datapath
smp_valid  in  1  1-cycle strobe, new sample on smp_data
smp_data  in  DATA_W  captured sample
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address (write or read)
mem_wdata  out  DATA_W  RAM write data
rd_req  in  1  reader request; held high until granted
rd_addr  in  ADDR_W  reader address, valid while rd_req high
rd_gnt  out  1  reader owns RAM port this cycle; read data appears per RAM latency
busy  out  1  high in WARMUP or RECORD
done  out  1  high in DONE state
sample_count  out  ADDR_W+1  samples written this session

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; mic_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_gnt=0, busy=0, done=0, sample_count=0.
  - Pending write cleared. A session in progress is abandoned; RAM contents are not touched.
- States IDLE, WARMUP, RECORD, DONE:
  - IDLE/DONE + start: latch len (0→2^ADDR_W) as target; clear sample_count, write pointer and warm counter. Next state WARMUP, or RECORD if WARMUP=0. mic_en=1 from the next cycle.
  - WARMUP: each smp_valid increments warm counter, sample discarded. The WARMUP-th valid moves to RECORD; that sample is not stored.
  - RECORD: smp_valid registers smp_data into a 1-deep pending slot.
  - Following cycle: mem_we=1, mem_addr=write pointer, mem_wdata=pending data. Write pointer and sample_count +1.
  - When sample_count reaches target (on the cycle of the final write) → DONE.
  - stop in WARMUP → DONE immediately, sample_count=0.
  - stop in RECORD → DONE after any pending write completes. A sample strobed in the same cycle as stop is captured and written.
  - DONE: mic_en=0, done=1 held until next accepted start. start in WARMUP/RECORD ignored.
- Arbitration (per cycle, combinational from registered state):
  - Pending write present → write owns port, rd_gnt=0.
  - Otherwise rd_req=1 → rd_gnt=1, mem_addr=rd_addr, mem_we=0.
  - Otherwise port idle: mem_we=0, mem_addr holds last value.
  - Reads allowed in every state, including during RECORD.
  - Pending lasts exactly one cycle; samples arrive ≥2 cycles apart (mic bit clock ≪ clk), so no overrun path exists.
- Latency: smp_valid at cycle N → mem_we at N+1. Reader waits at most 1 cycle for grant.
- Write pointer wraps never: target ≤ 2^ADDR_W. sample_count reaches 2^ADDR_W only with len=0.

Test Plan:
- WARMUP=4, len=8, start, 12 smp_valid with data 1..12 → data 5..12 written to addr 0..7, one write cycle after each strobe. done=1, sample_count=8, mic_en=0 after the last write.
- len=0, ADDR_W=4 → 16 samples stored at addr 0..15, sample_count=16, DONE.
- stop asserted with 3rd recorded smp_valid (len=10) → 3 samples at addr 0..2, DONE, sample_count=3. stop during WARMUP → DONE, sample_count=0, no mem_we.
- rd_req held with rd_addr=5 through a strobe → rd_gnt=0 in the write cycle, rd_gnt=1 next cycle with mem_addr=5. Idle rd_req → granted same cycle.
- reset low mid-RECORD after 4 writes → all outputs 0 immediately. After release, start re-records from addr 0.
- start pulsed during RECORD → ignored, sample_count continues. start in DONE → new session, done drops next cycle.
